// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the vblank scheduler state type.
// Imported by the vblank update scheduler and any later display-side arbiters.
package vga_pkg;

    typedef enum logic [1:0] {
        StWaitVb,
        StArb,
        StGrant
    } sched_state_e;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 521;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker (purely combinational).
// Finds the first set bit of pend_i, scanning upward from rr_ptr_i with wrap-around.
// Ports:
//   pend_i   - pending request vector
//   rr_ptr_i - index the scan starts from
//   idx_o    - index of the selected request (0 when nothing is pending)
//   valid_o  - high when any request is pending
module rr_priority_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pend_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr_i) + i) % N_REQ);
            if (!valid_o && pend_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Vertical-blanking update scheduler.
// Latches pending updater requests at each vblank start and grants them one at a time in
// round-robin order, with a per-grant timeout, so shared display state is only touched
// while the beam is outside the visible area.
// Ports:
//   clk_i           - pixel clock
//   rst_ni          - asynchronous active-low reset
//   y_coord_i       - current line from the VGA timing generator
//   req_i           - level request per updater
//   done_i          - one-cycle completion pulse from the granted updater
//   grant_o         - one-hot grant, zero when idle
//   frame_tick_o    - one-cycle pulse at vblank start
//   busy_o          - high while a pass is in progress
//   timeout_pulse_o - one-cycle pulse when a grant is revoked by timeout
//   overrun_o       - sticky: active video resumed with work outstanding
//   frame_count_o   - frames since reset, wrapping
module vblank_update_scheduler #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [9:0]       y_coord_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] done_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             frame_tick_o,
    output logic             busy_o,
    output logic             timeout_pulse_o,
    output logic             overrun_o,
    output logic [7:0]       frame_count_o
);

    import vga_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned TW    = $clog2(TIMEOUT);

    sched_state_e     state_q, state_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             vb_q;
    logic             frame_tick_q, frame_tick_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       frame_count_q, frame_count_d;

    logic             in_vblank;
    logic             vb_rise;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    // Unsigned compare: wrapped back-porch line numbers also count as blanking.
    assign in_vblank = (32'(y_coord_i) >= V_ACTIVE);
    assign vb_rise   = in_vblank & ~vb_q;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .pend_i   (pend_q),
        .rr_ptr_i (rr_ptr_q),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        frame_tick_d  = 1'b0;
        timeout_d     = 1'b0;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;

        unique case (state_q)
            StWaitVb: begin
                grant_d = '0;
                if (vb_rise) begin
                    pend_d        = req_i;
                    frame_tick_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    overrun_d     = 1'b0;
                    state_d       = StArb;
                end
            end
            StArb: begin
                if (!in_vblank) begin
                    if (pend_q != '0) begin
                        overrun_d = 1'b1;
                    end
                    pend_d  = '0;
                    state_d = StWaitVb;
                end else if (!pick_valid) begin
                    state_d = StWaitVb;
                end else begin
                    grant_d          = N_REQ'(1) << pick_idx;
                    pend_d[pick_idx] = 1'b0;
                    rr_ptr_d         = (32'(pick_idx) == N_REQ - 1) ? '0
                                                                    : pick_idx + IDX_W'(1);
                    timer_d          = '0;
                    state_d          = StGrant;
                end
            end
            StGrant: begin
                // Completion beats both timeout and end of blanking.
                if ((done_i & grant_q) != '0) begin
                    grant_d = '0;
                    state_d = StArb;
                end else if (32'(timer_q) == TIMEOUT - 1) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    state_d   = StArb;
                end else if (!in_vblank) begin
                    overrun_d = 1'b1;
                    pend_d    = '0;
                    grant_d   = '0;
                    state_d   = StWaitVb;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = StWaitVb;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StWaitVb;
            pend_q        <= '0;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
            // Start "already in blanking" so a mid-vblank reset release waits for a real edge.
            vb_q          <= 1'b1;
            frame_tick_q  <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            vb_q          <= in_vblank;
            frame_tick_q  <= frame_tick_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign grant_o         = grant_q;
    assign frame_tick_o    = frame_tick_q;
    assign busy_o          = (state_q != StWaitVb);
    assign timeout_pulse_o = timeout_q;
    assign overrun_o       = overrun_q;
    assign frame_count_o   = frame_count_q;

endmodule
